// File: rtl/id_ex_skid_latch_if.sv
// rtl/id_ex_skid_latch_if.sv - decode->execute handshake bundle for id_ex_skid_latch
interface id_ex_skid_latch_if #(
    parameter int DATA_W = 128,
    parameter int ID_W   = 5,
    parameter int DEPTH  = 2
);
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_W-1:0]                in_payload;
    logic [ID_W-1:0]                  in_ins_id;
    logic                             clr_latch;
    logic                             kill_valid;
    logic [ID_W-1:0]                  kill_id;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_W-1:0]                out_payload;
    logic [ID_W-1:0]                  out_ins_id;
    logic                             out_ins_nop;
    logic [$clog2(DEPTH+1)-1:0]       occupancy;

    // latch side
    modport slave (
        input  in_valid, in_payload, in_ins_id, clr_latch, kill_valid, kill_id, out_ready,
        output in_ready, out_valid, out_payload, out_ins_id, out_ins_nop, occupancy
    );

    // decode/execute side
    modport master (
        output in_valid, in_payload, in_ins_id, clr_latch, kill_valid, kill_id, out_ready,
        input  in_ready, out_valid, out_payload, out_ins_id, out_ins_nop, occupancy
    );
endinterface

// File: rtl/id_ex_skid_latch.sv
// rtl/id_ex_skid_latch.sv - decode->execute register with DEPTH-entry skid queue; optional selective kill via ID_EX_SKID_KILL_EN
module id_ex_skid_latch #(
    parameter int DATA_W = 128,
    parameter int ID_W   = 5,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_skid_latch_if.slave   bus
);
    // Entries at or beyond the occupancy are always held at zero, so the head
    // register doubles as the zero-when-empty output.
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [ID_W-1:0]   id_d   [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              push;
    logic              pop;
    logic              in_ready;

    // Only registered state decides acceptance, keeping out_ready off the decode path.
    assign in_ready = (cnt_q < CNT_W'(DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign pop      = (cnt_q != '0) && bus.out_ready;

`ifdef ID_EX_SKID_KILL_EN
    // Wrap-aware ROB age compare: id is younger when it sits in the half-ring after kill.
    function automatic logic is_younger(input logic [ID_W-1:0] id, input logic [ID_W-1:0] kid);
        logic [ID_W-1:0] diff;
        diff = id - kid;
        return (diff != '0) && !diff[ID_W-1];
    endfunction

    logic [CNT_W-1:0] cnt_mid;
`else
    logic unused_kill;
    assign unused_kill = ^{bus.kill_valid, bus.kill_id};
`endif

    // Next-state: pop shifts toward head, push appends at the tail, kill compacts survivors.
    always_comb begin
        data_d = data_q;
        id_d   = id_q;
        cnt_d  = cnt_q;
`ifdef ID_EX_SKID_KILL_EN
        cnt_mid = '0;
`endif
        if (pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                data_d[i] = data_d[i+1];
                id_d[i]   = id_d[i+1];
            end
            data_d[DEPTH-1] = '0;
            id_d[DEPTH-1]   = '0;
            cnt_d           = cnt_d - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == cnt_d) begin
                    data_d[i] = bus.in_payload;
                    id_d[i]   = bus.in_ins_id;
                end
            end
            cnt_d = cnt_d + 1'b1;
        end
`ifdef ID_EX_SKID_KILL_EN
        cnt_mid = cnt_d;
        if (bus.kill_valid) begin
            // Walk from the tail so a removal only shifts entries already judged.
            for (int i = DEPTH-1; i >= 0; i--) begin
                if ((CNT_W'(i) < cnt_mid) && is_younger(id_d[i], bus.kill_id)) begin
                    for (int j = i; j < DEPTH-1; j++) begin
                        data_d[j] = data_d[j+1];
                        id_d[j]   = id_d[j+1];
                    end
                    data_d[DEPTH-1] = '0;
                    id_d[DEPTH-1]   = '0;
                    cnt_d           = cnt_d - 1'b1;
                end
            end
        end
`endif
        if (bus.clr_latch) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
                id_d[i]   = '0;
            end
            cnt_d = '0;
        end
    end

    // Queue state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                id_q[i]   <= id_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (cnt_q != '0);
    assign bus.out_ins_nop = (cnt_q == '0);
    assign bus.out_payload = data_q[0];
    assign bus.out_ins_id  = id_q[0];
    assign bus.occupancy   = cnt_q;
endmodule

// File: tb/tb_id_ex_skid_latch.sv
// tb/tb_id_ex_skid_latch.sv - randomized and directed bench for id_ex_skid_latch (DEPTH 2 and 1)
module tb_id_ex_skid_latch;
    localparam int DATA_W = 128;
    localparam int ID_W   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_payload = '0;
    logic [ID_W-1:0]   in_ins_id = '0;
    logic              out_ready = 1'b0;
    logic              clr_latch = 1'b0;
    logic              kill_valid = 1'b0;
    logic [ID_W-1:0]   kill_id = '0;

    always #5 clk = ~clk;

    id_ex_skid_latch_if #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(2)) b2 ();
    id_ex_skid_latch_if #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(1)) b1 ();

    assign b2.in_valid = in_valid;   assign b1.in_valid = in_valid;
    assign b2.in_payload = in_payload; assign b1.in_payload = in_payload;
    assign b2.in_ins_id = in_ins_id; assign b1.in_ins_id = in_ins_id;
    assign b2.out_ready = out_ready; assign b1.out_ready = out_ready;
    assign b2.clr_latch = clr_latch; assign b1.clr_latch = clr_latch;
    assign b2.kill_valid = kill_valid; assign b1.kill_valid = kill_valid;
    assign b2.kill_id = kill_id;     assign b1.kill_id = kill_id;

    id_ex_skid_latch #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    id_ex_skid_latch #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct packed {
        logic [DATA_W-1:0] p;
        logic [ID_W-1:0]   id;
    } ent_t;

    ent_t mq [2][$];   // [0] models DEPTH=2, [1] models DEPTH=1
    bit   started = 1'b0;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit younger(input logic [ID_W-1:0] id, input logic [ID_W-1:0] k);
        int d;
        d = (int'(id) - int'(k) + (1 << ID_W)) % (1 << ID_W);
        return (d >= 1) && (d <= (1 << (ID_W-1)) - 1);
    endfunction

    // Reference queues: pop first, then push, then kill filter; flush/reset empty everything.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            int  dep;
            bit  pu, po;
            ent_t keep[$];
            dep = (n == 0) ? 2 : 1;
            pu  = in_valid && (mq[n].size() < dep);
            po  = (mq[n].size() > 0) && out_ready;
            if (reset || clr_latch) begin
                mq[n].delete();
            end else begin
                if (po) void'(mq[n].pop_front());
                if (pu) mq[n].push_back('{p: in_payload, id: in_ins_id});
`ifdef ID_EX_SKID_KILL_EN
                if (kill_valid) begin
                    keep = {};
                    foreach (mq[n][i]) if (!younger(mq[n][i].id, kill_id)) keep.push_back(mq[n][i]);
                    mq[n] = keep;
                end
`endif
            end
        end
        started = 1'b1;
    end

    task automatic cmp(input int n, input string tag, input logic ov, input logic [DATA_W-1:0] op,
                       input logic [ID_W-1:0] oid, input logic nop, input int occ, input logic rdy);
        int sz;
        int dep;
        sz  = mq[n].size();
        dep = (n == 0) ? 2 : 1;
        chk({tag, "_occupancy"}, DATA_W'(occ), DATA_W'(sz));
        chk({tag, "_out_valid"}, DATA_W'(ov), DATA_W'(sz > 0));
        chk({tag, "_out_ins_nop"}, DATA_W'(nop), DATA_W'(sz == 0));
        chk({tag, "_in_ready"}, DATA_W'(rdy), DATA_W'(sz < dep));
        chk({tag, "_out_payload"}, op, (sz > 0) ? mq[n][0].p : '0);
        chk({tag, "_out_ins_id"}, DATA_W'(oid), (sz > 0) ? DATA_W'(mq[n][0].id) : '0);
    endtask

    // Every cycle both DUTs are held against the reference queues.
    always @(negedge clk) begin
        if (started) begin
            cmp(0, "d2", b2.out_valid, b2.out_payload, b2.out_ins_id, b2.out_ins_nop, int'(b2.occupancy), b2.in_ready);
            cmp(1, "d1", b1.out_valid, b1.out_payload, b1.out_ins_id, b1.out_ins_nop, int'(b1.occupancy), b1.in_ready);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int id);
        in_valid   = v;
        in_ins_id  = ID_W'(id);
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic flush();
        clr_latch = 1'b1; in_valid = 1'b0; kill_valid = 1'b0;
        step();
        clr_latch = 1'b0;
    endtask

    initial begin
        // reset for two cycles
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", DATA_W'(b2.out_valid), '0);
        chk("rst_nop", DATA_W'(b2.out_ins_nop), DATA_W'(1));
        chk("rst_occ", DATA_W'(b2.occupancy), '0);
        chk("rst_in_ready", DATA_W'(b2.in_ready), DATA_W'(1));
        chk("rst_payload", b2.out_payload, '0);

        // back-to-back stream on DEPTH=2
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b1, k);
            step();
            chk("stream_id", DATA_W'(b2.out_ins_id), DATA_W'(k));
            chk("stream_ready", DATA_W'(b2.in_ready), DATA_W'(1));
        end
        set_in(1'b0, 0);
        step();
        chk("stream_drain", DATA_W'(b2.out_valid), '0);

        // skid: two entries held while execute stalls
        flush();
        out_ready = 1'b0;
        set_in(1'b1, 3); step();
        set_in(1'b1, 4); step();
        set_in(1'b1, 5); step();
        chk("skid_occ", DATA_W'(b2.occupancy), DATA_W'(2));
        chk("skid_ready", DATA_W'(b2.in_ready), '0);
        chk("skid_head", DATA_W'(b2.out_ins_id), DATA_W'(3));
        out_ready = 1'b1; set_in(1'b0, 0);
        step();
        chk("skid_drain4", DATA_W'(b2.out_ins_id), DATA_W'(4));
        chk("skid_occ1", DATA_W'(b2.occupancy), DATA_W'(1));
        step();
        chk("skid_empty", DATA_W'(b2.out_valid), '0);

        // DEPTH=1: in_ready alternates under constant traffic
        flush();
        out_ready = 1'b1;
        chk("d1_ready0", DATA_W'(b1.in_ready), DATA_W'(1));
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 10 + k);
            step();
            chk("d1_ready_toggle", DATA_W'(b1.in_ready), DATA_W'(k % 2));
        end
        set_in(1'b0, 0); step();

        // flush overrides a same-cycle push
        flush();
        out_ready = 1'b0;
        set_in(1'b1, 6); step();
        set_in(1'b1, 7); step();
        chk("flush_pre_occ", DATA_W'(b2.occupancy), DATA_W'(2));
        clr_latch = 1'b1; set_in(1'b1, 8);
        step();
        clr_latch = 1'b0; set_in(1'b0, 0);
        chk("flush_occ", DATA_W'(b2.occupancy), '0);
        chk("flush_nop", DATA_W'(b2.out_ins_nop), DATA_W'(1));
        out_ready = 1'b1;
        step();
        chk("flush_no8", DATA_W'(b2.out_valid), '0);

        // wrap-aware kill
        flush();
        out_ready = 1'b0;
        set_in(1'b1, 30); step();
        set_in(1'b1, 2);  step();
        set_in(1'b0, 0);
        kill_valid = 1'b1; kill_id = ID_W'(31);
        step();
        kill_valid = 1'b0;
`ifdef ID_EX_SKID_KILL_EN
        chk("kill_occ", DATA_W'(b2.occupancy), DATA_W'(1));
`else
        chk("kill_occ", DATA_W'(b2.occupancy), DATA_W'(2));
`endif
        chk("kill_head", DATA_W'(b2.out_ins_id), DATA_W'(30));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)));
            out_ready  = $urandom_range(0, 9) < 7;
            clr_latch  = $urandom_range(0, 39) == 0;
            kill_valid = $urandom_range(0, 9) == 0;
            kill_id    = ID_W'($urandom_range(0, 31));
            reset      = $urandom_range(0, 199) == 0;
            step();
        end
        reset = 1'b0; clr_latch = 1'b0; kill_valid = 1'b0; in_valid = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
